// File: rtl/serial_reg_loader_if.sv
// Host-side serial line plus the APU register-write port of serial_reg_loader.
// Combinational bundle only; no latency.
// No backpressure: wr_en is a fire-and-forget strobe.
interface serial_reg_loader_if;
  logic       rx;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       link;
  logic       frame_err;

  // master drives the serial line (host side); slave is the loader itself
  modport master (output rx, input wr_en, wr_addr, wr_data, link, frame_err);
  modport slave  (input rx, output wr_en, wr_addr, wr_data, link, frame_err);
endinterface

// File: rtl/serial_reg_loader.sv
// UART receiver turning (address, data) byte pairs into APU register-write strobes; 8N1, or 8E1 when PARITY_EN is defined.
// Latency: wr_en / frame_err assert 1 cycle after the stop-bit mid-sample.
// Backpressure: none; the serial line cannot be stalled, so writes are single-cycle strobes.
module serial_reg_loader #(
  parameter int CLKRATE   = 2_000_000,
  parameter int BAUDRATE  = 9600,
  parameter int IDLE_BITS = 20,
  parameter int LINK_HOLD = 100_000
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_reg_loader_if.slave bus
);

  localparam int DIV  = (CLKRATE + BAUDRATE / 2) / BAUDRATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int GAP  = IDLE_BITS * DIV;
  localparam int GW   = $clog2(GAP + 1);
  localparam int LW   = $clog2(LINK_HOLD + 1);

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);
  localparam logic [LW-1:0] LINK_LOAD = LW'(LINK_HOLD);

  // RX_TAIL finishes the stop bit after a framing error so a held-low line
  // (break) restarts exactly one frame time later instead of waiting for an edge.
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_TAIL
  } rx_state_t;

  typedef enum logic {
    PAIR_WAIT_ADDR,
    PAIR_WAIT_DATA
  } pair_state_t;

  // synchroniser and edge detect
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  // receiver
  rx_state_t         rx_state_q, rx_state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              stop_ok;
  logic              byte_vld;
  logic              byte_err;
`ifdef PARITY_EN
  logic              par_err_q, par_err_d;
`endif

  // pair decoder
  pair_state_t       pair_q, pair_d;
  logic [4:0]        addr_q, addr_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              wr_fire;

  // outputs
  logic              wr_en_q;
  logic [4:0]        wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              frame_err_q;
  logic [LW-1:0]     link_cnt_q, link_cnt_d;
  logic              link_q;

  // two-flop synchroniser on the asynchronous rx pin, plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // receiver next state: start qualification, mid-bit sampling, stop/parity verdict
  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    stop_ok    = 1'b0;
    byte_vld   = 1'b0;
    byte_err   = 1'b0;
`ifdef PARITY_EN
    par_err_d  = par_err_q;
`endif
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d      = '0;
          bit_d      = '0;
          // a start bit that is high again at mid-bit was a glitch
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef PARITY_EN
      RX_PARITY: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d      = '0;
          par_err_d  = rx_sync_q ^ (^shift_q);
          rx_state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      RX_STOP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
`ifdef PARITY_EN
          stop_ok = rx_sync_q && !par_err_q;
`else
          stop_ok = rx_sync_q;
`endif
          byte_vld   = stop_ok;
          byte_err   = !stop_ok;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_TAIL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_TAIL: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d      = '0;
          // line still low at the frame boundary: treat it as the next start bit
          rx_state_d = rx_sync_q ? RX_IDLE : RX_START;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        cnt_d      = '0;
      end
    endcase
  end

  // receiver state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
`ifdef PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
`ifdef PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  // pair decoder: address byte then data byte; errors and long idle gaps resynchronise
  always_comb begin
    pair_d  = pair_q;
    addr_d  = addr_q;
    gap_d   = '0;
    wr_fire = 1'b0;
    case (pair_q)
      PAIR_WAIT_ADDR: begin
        if (byte_vld && (shift_q[7:5] == 3'b010)) begin
          addr_d = shift_q[4:0];
          pair_d = PAIR_WAIT_DATA;
        end
      end
      PAIR_WAIT_DATA: begin
        if (byte_err) begin
          pair_d = PAIR_WAIT_ADDR;
        end else if (byte_vld) begin
          wr_fire = 1'b1;
          pair_d  = PAIR_WAIT_ADDR;
        end else if (rx_state_q == RX_IDLE) begin
          if (gap_q == GAP_LAST) begin
            pair_d = PAIR_WAIT_ADDR;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end
      default: pair_d = PAIR_WAIT_ADDR;
    endcase
  end

  // pair decoder registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_q <= PAIR_WAIT_ADDR;
      addr_q <= '0;
      gap_q  <= '0;
    end else begin
      pair_q <= pair_d;
      addr_q <= addr_d;
      gap_q  <= gap_d;
    end
  end

  // link hold counter: reload on every valid byte, count down to zero and stay there
  always_comb begin
    link_cnt_d = link_cnt_q;
    if (byte_vld) begin
      link_cnt_d = LINK_LOAD;
    end else if (link_cnt_q != '0) begin
      link_cnt_d = link_cnt_q - LW'(1);
    end
  end

  // registered outputs; write address/data hold until the next write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      link_cnt_q  <= '0;
      link_q      <= 1'b0;
    end else begin
      wr_en_q     <= wr_fire;
      frame_err_q <= byte_err;
      link_cnt_q  <= link_cnt_d;
      link_q      <= (link_cnt_d != '0);
      if (wr_fire) begin
        wr_addr_q <= addr_q;
        wr_data_q <= shift_q;
      end
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.frame_err = frame_err_q;
  assign bus.link      = link_q;

endmodule
